// File: rtl/clk_period_meter_pkg.sv
// Shared definitions for the clock period meter.
//   meas_state_e     : measurement FSM states
//   MCLK_HZ          : nominal board clock frequency
//   DEF_CNT_W        : default counter width (holds 5_000_002 for a 10 Hz input)
//   DEF_TIMEOUT      : default loss-of-signal timeout in mclk cycles
//   DEF_SYNC_STAGES  : default synchronizer depth
package clk_period_meter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } meas_state_e;

   localparam int MCLK_HZ         = 50_000_000;
   localparam int DEF_CNT_W       = 24;
   localparam int DEF_TIMEOUT     = 10_000_000;
   localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_period_meter_if.sv
// Signal bundle between the period meter and its consumer (LED / 7-seg logic).
//   sig_in        : slow square wave to measure (driven by the consumer side)
//   sig_sync      : synchronized copy of sig_in, handy for an activity LED
//   period        : last period, mclk cycles, rise-to-rise
//   high_time     : last high time, mclk cycles, rise-to-fall
//   period_valid  : 1-cycle pulse when period/high_time update
//   locked        : a full period has been measured and no timeout since
//   timeout       : 1-cycle pulse when the signal is declared lost
// Modports: master = meter, slave = consumer.
interface clk_period_meter_if
   import clk_period_meter_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);
   logic             sig_in;
   logic             sig_sync;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             period_valid;
   logic             locked;
   logic             timeout;

   modport master (
      input  sig_in,
      output sig_sync, period, high_time, period_valid, locked, timeout
   );

   modport slave (
      output sig_in,
      input  sig_sync, period, high_time, period_valid, locked, timeout
   );
endinterface

// File: rtl/clk_period_meter_sync_edge_det.sv
// Synchronizer plus edge detector for an asynchronous single-bit input.
// Reusable for push buttons and other slow external signals.
//   mclk  : clock
//   rst   : synchronous active-high reset, clears the chain
//   d     : asynchronous input
//   q     : synchronized level
//   rise  : 1 for one cycle after q goes 0 -> 1
//   fall  : 1 for one cycle after q goes 1 -> 0
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic mclk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d;

   always_ff @(posedge mclk) begin
      if (rst) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         s_d    <= sync_q[SYNC_STAGES-1];
      end
   end

   assign q    = sync_q[SYNC_STAGES-1];
   assign rise = q & ~s_d;
   assign fall = ~q & s_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in mclk
// cycles, pulses period_valid once per period and drops lock on timeout.
//   mclk  : board clock, all logic on posedge
//   rst   : synchronous active-high reset
//   bus   : clk_period_meter_if.master (sig_in in, measurement results out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no edge seen yet (or signal lost); cnt held at 0
// MEAS  | counting mclk cycles since the last rising edge
module clk_period_meter
   import clk_period_meter_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                mclk,
   input  logic                rst,
   clk_period_meter_if.master  bus
);

   localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic rise;
   logic fall;

   meas_state_e      state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [CNT_W-1:0] hi_q,     hi_d;
   logic             have_q,   have_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q,   high_d;
   logic             valid_q,  valid_d;
   logic             lock_q,   lock_d;
   logic             to_q,     to_d;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .mclk (mclk),
      .rst  (rst),
      .d    (bus.sig_in),
      .q    (bus.sig_sync),
      .rise (rise),
      .fall (fall)
   );

   always_ff @(posedge mclk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         have_q   <= 1'b0;
         period_q <= '0;
         high_q   <= '0;
         valid_q  <= 1'b0;
         lock_q   <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         have_q   <= have_d;
         period_q <= period_d;
         high_q   <= high_d;
         valid_q  <= valid_d;
         lock_q   <= lock_d;
         to_q     <= to_d;
      end
   end

   // cnt is 1 in the cycle after a rise pulse, so at the next rise it holds
   // the exact rise-to-rise distance; the same holds for the fall capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      have_d   = have_q;
      period_d = period_q;
      high_d   = high_q;
      valid_d  = 1'b0;
      lock_d   = lock_q;
      to_d     = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rise) begin
               state_d = MEAS;
               cnt_d   = CNT_ONE;
               have_d  = 1'b0;
            end
         end

         MEAS: begin
            if (rise) begin
               // A rise on the timeout cycle still completes the period.
               period_d = cnt_q;
               high_d   = hi_q;
               valid_d  = 1'b1;
               lock_d   = have_q;
               cnt_d    = CNT_ONE;
            end else if (cnt_q == TO_CNT) begin
               to_d    = 1'b1;
               lock_d  = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               if (fall) begin
                  hi_d   = cnt_q;
                  have_d = 1'b1;
               end
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.period       = period_q;
   assign bus.high_time    = high_q;
   assign bus.period_valid = valid_q;
   assign bus.locked       = lock_q;
   assign bus.timeout      = to_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter. A cycle-level reference model watches the
// sampled sig_in and predicts every period_valid / timeout event from edge
// timestamps; a monitor pops those predictions as the DUT emits events.
module tb_clk_period_meter;

   localparam int CNT_W       = 16;
   localparam int TIMEOUT     = 100;
   localparam int SYNC_STAGES = 2;
   // sig_in change (just after an edge) to output pulse, in bench cycles
   localparam int LAT         = SYNC_STAGES + 1;

   typedef struct {
      int t;
      int per;
      int hi;
      bit lk;
   } exp_t;

   logic mclk = 1'b0;
   logic rst  = 1'b1;

   clk_period_meter_if #(.CNT_W(CNT_W)) bus ();

   clk_period_meter #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 mclk = ~mclk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_valid  = 0;
   int n_to     = 0;
   int obs_per[$];

   exp_t vq[$];
   int   tq[$];

   bit m_active   = 1'b0;
   bit m_prev     = 1'b0;
   bit m_have     = 1'b0;
   bit m_locked   = 1'b0;
   int m_rise     = 0;
   int m_hi       = 0;
   int m_last_per = 0;

   // Reference model: works on sampled sig_in, one step per mclk edge.
   initial begin
      forever begin
         bit s;
         exp_t e;
         @(posedge mclk);
         s = bus.sig_in;
         if (rst) begin
            m_active   = 1'b0;
            m_have     = 1'b0;
            m_locked   = 1'b0;
            m_hi       = 0;
            m_last_per = 0;
            vq.delete();
            tq.delete();
         end else if (s && !m_prev) begin
            if (m_active) begin
               e.t   = cyc + LAT;
               e.per = cyc - m_rise;
               e.hi  = m_hi;
               e.lk  = m_have;
               vq.push_back(e);
               m_locked   = m_have;
               m_last_per = e.per;
            end else begin
               m_active = 1'b1;
               m_have   = 1'b0;
            end
            m_rise = cyc;
         end else if (m_active && (cyc - m_rise == TIMEOUT)) begin
            tq.push_back(cyc + LAT);
            m_active = 1'b0;
            m_locked = 1'b0;
         end else if (!s && m_prev && m_active) begin
            m_hi   = cyc - m_rise;
            m_have = 1'b1;
         end
         m_prev = rst ? 1'b0 : s;
         cyc    = cyc + 1;
      end
   end

   // Monitor: every DUT event must match the next model prediction.
   initial begin
      forever begin
         exp_t e;
         int   tt;
         @(negedge mclk);
         if (bus.period_valid === 1'b1) begin
            n_valid = n_valid + 1;
            obs_per.push_back(int'(bus.period));
            n_checks = n_checks + 1;
            if (vq.size() == 0) begin
               n_errors = n_errors + 1;
               $display("FAIL spurious_valid: valid at cycle %0d, period %0d, none expected", cyc, bus.period);
            end else begin
               e = vq.pop_front();
               n_checks = n_checks + 4;
               if (cyc !== e.t) begin
                  n_errors = n_errors + 1;
                  $display("FAIL valid_time: got cycle %0d expected %0d", cyc, e.t);
               end
               if (bus.period !== 16'(e.per)) begin
                  n_errors = n_errors + 1;
                  $display("FAIL valid_period: got %0d expected %0d", bus.period, e.per);
               end
               if (bus.high_time !== 16'(e.hi)) begin
                  n_errors = n_errors + 1;
                  $display("FAIL valid_high_time: got %0d expected %0d", bus.high_time, e.hi);
               end
               if (bus.locked !== e.lk) begin
                  n_errors = n_errors + 1;
                  $display("FAIL valid_locked: got %0b expected %0b", bus.locked, e.lk);
               end
            end
         end
         if (bus.timeout === 1'b1) begin
            n_to = n_to + 1;
            n_checks = n_checks + 1;
            if (tq.size() == 0) begin
               n_errors = n_errors + 1;
               $display("FAIL spurious_timeout: timeout at cycle %0d, none expected", cyc);
            end else begin
               tt = tq.pop_front();
               n_checks = n_checks + 2;
               if (cyc !== tt) begin
                  n_errors = n_errors + 1;
                  $display("FAIL timeout_time: got cycle %0d expected %0d", cyc, tt);
               end
               if (bus.locked !== 1'b0) begin
                  n_errors = n_errors + 1;
                  $display("FAIL timeout_locked: got %0b expected 0", bus.locked);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic hold(input logic v, input int n);
      bus.sig_in = v;
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic wave(input int per, input int hi, input int reps);
      for (int i = 0; i < reps; i++) begin
         hold(1'b1, hi);
         hold(1'b0, per - hi);
      end
   endtask

   task automatic test_reset;
      int v0;
      rst = 1'b1;
      hold(1'b1, 1);
      hold(1'b0, 1);
      hold(1'b1, 1);
      n_checks = n_checks + 5;
      if (bus.period !== 16'd0) begin
         n_errors = n_errors + 1;
         $display("FAIL reset_period: got %0d expected 0", bus.period);
      end
      if (bus.high_time !== 16'd0) begin
         n_errors = n_errors + 1;
         $display("FAIL reset_high_time: got %0d expected 0", bus.high_time);
      end
      if (bus.period_valid !== 1'b0) begin
         n_errors = n_errors + 1;
         $display("FAIL reset_valid: got %0b expected 0", bus.period_valid);
      end
      if (bus.locked !== 1'b0) begin
         n_errors = n_errors + 1;
         $display("FAIL reset_locked: got %0b expected 0", bus.locked);
      end
      if (bus.timeout !== 1'b0) begin
         n_errors = n_errors + 1;
         $display("FAIL reset_timeout: got %0b expected 0", bus.timeout);
      end
      bus.sig_in = 1'b0;
      rst = 1'b0;
      hold(1'b0, 3);
      v0 = n_valid;
      wave(10, 5, 1);
      n_checks = n_checks + 1;
      if (n_valid - v0 !== 0) begin
         n_errors = n_errors + 1;
         $display("FAIL reset_first_rise: got %0d valids expected 0", n_valid - v0);
      end
   endtask

   task automatic test_period10;
      int v0 = n_valid;
      wave(10, 5, 6);
      n_checks = n_checks + 4;
      if (n_valid - v0 !== 6) begin
         n_errors = n_errors + 1;
         $display("FAIL p10_count: got %0d valids expected 6", n_valid - v0);
      end
      if (bus.period !== 16'd10) begin
         n_errors = n_errors + 1;
         $display("FAIL p10_period: got %0d expected 10", bus.period);
      end
      if (bus.high_time !== 16'd5) begin
         n_errors = n_errors + 1;
         $display("FAIL p10_high_time: got %0d expected 5", bus.high_time);
      end
      if (bus.locked !== 1'b1) begin
         n_errors = n_errors + 1;
         $display("FAIL p10_locked: got %0b expected 1", bus.locked);
      end
   endtask

   task automatic test_duty_change;
      int v0 = n_valid;
      wave(20, 3, 4);
      n_checks = n_checks + 3;
      if (n_valid - v0 !== 4) begin
         n_errors = n_errors + 1;
         $display("FAIL duty_count: got %0d valids expected 4", n_valid - v0);
      end
      if (bus.period !== 16'd20) begin
         n_errors = n_errors + 1;
         $display("FAIL duty_period: got %0d expected 20", bus.period);
      end
      if (bus.high_time !== 16'd3) begin
         n_errors = n_errors + 1;
         $display("FAIL duty_high_time: got %0d expected 3", bus.high_time);
      end
   endtask

   task automatic test_timeout;
      int t0 = n_to;
      int v0 = n_valid;
      hold(1'b0, 150);
      n_checks = n_checks + 4;
      if (n_to - t0 !== 1) begin
         n_errors = n_errors + 1;
         $display("FAIL timeout_count: got %0d timeouts expected 1", n_to - t0);
      end
      if (n_valid - v0 !== 0) begin
         n_errors = n_errors + 1;
         $display("FAIL timeout_valids: got %0d valids expected 0", n_valid - v0);
      end
      if (bus.locked !== 1'b0) begin
         n_errors = n_errors + 1;
         $display("FAIL timeout_unlock: got %0b expected 0", bus.locked);
      end
      if (bus.period !== 16'd20) begin
         n_errors = n_errors + 1;
         $display("FAIL timeout_period_kept: got %0d expected 20", bus.period);
      end
   endtask

   task automatic test_rise_at_timeout;
      int v0 = n_valid;
      int t0 = n_to;
      wave(10, 5, 1);
      wave(TIMEOUT, 50, 1);
      wave(10, 5, 2);
      n_checks = n_checks + 4;
      if (n_valid - v0 !== 3) begin
         n_errors = n_errors + 1;
         $display("FAIL edge_count: got %0d valids expected 3", n_valid - v0);
      end else if (obs_per[obs_per.size() - 2] !== TIMEOUT) begin
         n_errors = n_errors + 1;
         $display("FAIL edge_period: got %0d expected %0d", obs_per[obs_per.size() - 2], TIMEOUT);
      end
      if (n_to - t0 !== 0) begin
         n_errors = n_errors + 1;
         $display("FAIL edge_timeout: got %0d timeouts expected 0", n_to - t0);
      end
      if (bus.locked !== 1'b1) begin
         n_errors = n_errors + 1;
         $display("FAIL edge_locked: got %0b expected 1", bus.locked);
      end
      if (bus.period !== 16'd10) begin
         n_errors = n_errors + 1;
         $display("FAIL edge_last_period: got %0d expected 10", bus.period);
      end
   endtask

   task automatic test_reset_mid;
      int v0;
      hold(1'b0, 10);
      rst = 1'b1;
      hold(1'b0, 2);
      rst = 1'b0;
      hold(1'b0, 2);
      v0 = n_valid;
      wave(7, 3, 2);
      hold(1'b0, 20);
      n_checks = n_checks + 4;
      if (n_valid - v0 !== 1) begin
         n_errors = n_errors + 1;
         $display("FAIL rstmid_count: got %0d valids expected 1", n_valid - v0);
      end
      if (bus.period !== 16'd7) begin
         n_errors = n_errors + 1;
         $display("FAIL rstmid_period: got %0d expected 7", bus.period);
      end
      if (bus.high_time !== 16'd3) begin
         n_errors = n_errors + 1;
         $display("FAIL rstmid_high_time: got %0d expected 3", bus.high_time);
      end
      if (bus.locked !== 1'b1) begin
         n_errors = n_errors + 1;
         $display("FAIL rstmid_locked: got %0b expected 1", bus.locked);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 14; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            hold(1'b0, int'($urandom_range(90, 130)));
         end else begin
            int p = int'($urandom_range(2, 60));
            int h = int'($urandom_range(1, p - 1));
            wave(p, h, int'($urandom_range(1, 4)));
         end
      end
      hold(1'b0, LAT + 4);
      n_checks = n_checks + 4;
      if (vq.size() !== 0) begin
         n_errors = n_errors + 1;
         $display("FAIL random_missing_valid: %0d predicted valids never seen", vq.size());
      end
      if (tq.size() !== 0) begin
         n_errors = n_errors + 1;
         $display("FAIL random_missing_timeout: %0d predicted timeouts never seen", tq.size());
      end
      if (bus.locked !== m_locked) begin
         n_errors = n_errors + 1;
         $display("FAIL random_locked: got %0b expected %0b", bus.locked, m_locked);
      end
      if (bus.period !== 16'(m_last_per)) begin
         n_errors = n_errors + 1;
         $display("FAIL random_period: got %0d expected %0d", bus.period, m_last_per);
      end
   endtask

   initial begin
      bus.sig_in = 1'b0;
      rst        = 1'b1;
      @(posedge mclk);
      #1;
      test_reset();
      test_period10();
      test_duty_change();
      test_timeout();
      test_rise_at_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
